// File: rtl/mux_pkg.sv
// mux_pkg: shared constants, scan state encoding and clog2 for the scan mux
package mux_pkg;
  localparam logic MODE_STATIC = 1'b0;
  localparam logic MODE_SCAN = 1'b1;
  typedef enum logic {ST_IDLE, ST_DWELL} scan_state_e;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction
endpackage

// File: rtl/mux_n_to_1_scan_if.sv
// mux_n_to_1_scan_if: data lanes, mode/select controls and registered mux outputs
//   master drives in_data, mode, sel, ch_en; slave drives y, y_ch, y_valid, frame_start
interface mux_n_to_1_scan_if #(
  parameter int N_CH = 8,
  parameter int W = 8
);
  localparam int SEL_W = mux_pkg::clog2(N_CH);
  logic [N_CH*W-1:0] in_data;
  logic mode;
  logic [SEL_W-1:0] sel;
  logic [N_CH-1:0] ch_en;
  logic [W-1:0] y;
  logic [SEL_W-1:0] y_ch;
  logic y_valid;
  logic frame_start;
  modport master (output in_data, mode, sel, ch_en, input y, y_ch, y_valid, frame_start);
  modport slave (input in_data, mode, sel, ch_en, output y, y_ch, y_valid, frame_start);
endinterface

// File: rtl/mux_next_ch_find.sv
// mux_next_ch_find: next set bit of ch_en strictly above ptr, wrapping to the lowest
//   ch_en_i enable mask, ptr_i current index
//   nxt_o next index, wrap_o set when nxt_o <= ptr_i, any_o set when any bit is enabled
module mux_next_ch_find import mux_pkg::*; #(
  parameter int N_CH = 8
) (
  input  logic [N_CH-1:0]            ch_en_i,
  input  logic [clog2(N_CH)-1:0]     ptr_i,
  output logic [clog2(N_CH)-1:0]     nxt_o,
  output logic                       wrap_o,
  output logic                       any_o
);
  localparam int SEL_W = clog2(N_CH);
  logic hv;
  logic [SEL_W-1:0] hi, lo;
  // descending scan: the last hit kept is the lowest index
  always_comb begin
    hv = 1'b0;
    hi = '0;
    lo = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (ch_en_i[i] && i > int'(ptr_i)) begin
        hv = 1'b1;
        hi = SEL_W'(i);
      end
      if (ch_en_i[i]) lo = SEL_W'(i);
    end
  end
  assign nxt_o = hv ? hi : lo;
  assign wrap_o = !hv;
  assign any_o = |ch_en_i;
endmodule

// File: rtl/mux_n_to_1_scan.sv
// mux_n_to_1_scan: registered N:1 mux with static select or dwell-timed scan over an enable mask
//   clk, rst_n (async, active-low); bus: slave side of mux_n_to_1_scan_if
module mux_n_to_1_scan import mux_pkg::*; #(
  parameter int N_CH = 8,
  parameter int W = 8,
  parameter int DWELL = 4
) (
  input logic clk,
  input logic rst_n,
  mux_n_to_1_scan_if.slave bus
);
  localparam int SEL_W = clog2(N_CH);
  localparam int N_PAD = 2 ** SEL_W;
  localparam int CNT_W = clog2(DWELL + 1);
  scan_state_e state_q;
  logic [SEL_W-1:0] ptr_q;
  logic [CNT_W-1:0] dwell_q;
  logic [W-1:0] y_q;
  logic y_valid_q, fs_q;
  logic [SEL_W-1:0] find_ptr, nxt;
  logic wrap, any_en;
  logic [N_PAD-1:0] en_ext;
  logic [W-1:0] ch [N_PAD];
  // padded to a power of two so out-of-range indices read zero
  for (genvar k = 0; k < N_PAD; k++) begin : g_ch
    if (k < N_CH) begin : g_on
      assign ch[k] = bus.in_data[k*W +: W];
    end else begin : g_off
      assign ch[k] = '0;
    end
  end
  assign en_ext = N_PAD'(bus.ch_en);
  // from IDLE, searching above N_CH-1 yields the lowest enabled channel with wrap set
  assign find_ptr = (state_q == ST_DWELL) ? ptr_q : SEL_W'(N_CH - 1);
  mux_next_ch_find #(.N_CH(N_CH)) u_find (
    .ch_en_i(bus.ch_en),
    .ptr_i(find_ptr),
    .nxt_o(nxt),
    .wrap_o(wrap),
    .any_o(any_en)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q <= '0;
      dwell_q <= '0;
      y_q <= '0;
      y_valid_q <= 1'b0;
      fs_q <= 1'b0;
    end else if (bus.mode == MODE_STATIC) begin
      state_q <= ST_IDLE;
      ptr_q <= bus.sel;
      dwell_q <= '0;
      y_q <= ch[bus.sel];
      y_valid_q <= int'(bus.sel) < N_CH;
      fs_q <= 1'b0;
    end else if (!any_en) begin
      state_q <= ST_IDLE;
      dwell_q <= '0;
      y_q <= '0;
      y_valid_q <= 1'b0;
      fs_q <= 1'b0;
    end else if (state_q == ST_IDLE || dwell_q == CNT_W'(DWELL - 1) || !en_ext[ptr_q]) begin
      state_q <= ST_DWELL;
      ptr_q <= nxt;
      dwell_q <= '0;
      y_q <= ch[nxt];
      y_valid_q <= 1'b1;
      fs_q <= wrap;
    end else begin
      dwell_q <= dwell_q + CNT_W'(1);
      y_q <= ch[ptr_q];
      y_valid_q <= 1'b1;
      fs_q <= 1'b0;
    end
  end
  assign bus.y = y_q;
  assign bus.y_ch = ptr_q;
  assign bus.y_valid = y_valid_q;
  assign bus.frame_start = fs_q;
endmodule

// File: tb/tb_mux_n_to_1_scan.sv
// tb_mux_n_to_1_scan: directed checks of static select, scan sequencing, mask edits and mode switching
module tb_mux_n_to_1_scan;
  logic clk, rst_n;
  int total = 0;
  int bad = 0;
  mux_n_to_1_scan_if #(.N_CH(8), .W(8)) ia ();
  mux_n_to_1_scan_if #(.N_CH(6), .W(8)) ib ();
  mux_n_to_1_scan_if #(.N_CH(8), .W(8)) ic ();
  mux_n_to_1_scan #(.N_CH(8), .W(8), .DWELL(4)) u_a (.clk(clk), .rst_n(rst_n), .bus(ia));
  mux_n_to_1_scan #(.N_CH(6), .W(8), .DWELL(4)) u_b (.clk(clk), .rst_n(rst_n), .bus(ib));
  mux_n_to_1_scan #(.N_CH(8), .W(8), .DWELL(1)) u_c (.clk(clk), .rst_n(rst_n), .bus(ic));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    int seq [5] = '{0, 2, 5, 7, 0};
    int c;
    rst_n = 1'b1;
    ia.mode = 1'b0; ia.sel = '0; ia.ch_en = '0;
    ib.mode = 1'b0; ib.sel = '0; ib.ch_en = '0;
    ic.mode = 1'b0; ic.sel = '0; ic.ch_en = '0;
    for (int k = 0; k < 8; k++) ia.in_data[k*8 +: 8] = 8'(8'h10 + k);
    for (int k = 0; k < 6; k++) ib.in_data[k*8 +: 8] = 8'(8'h20 + k);
    for (int k = 0; k < 8; k++) ic.in_data[k*8 +: 8] = 8'(8'h30 + k);
    #2 rst_n = 1'b0;
    #1;
    check("rst_y", ia.y, 0);
    check("rst_ych", ia.y_ch, 0);
    check("rst_valid", ia.y_valid, 0);
    check("rst_fs", ia.frame_start, 0);
    #5 rst_n = 1'b1;
    ia.sel = 3'd5;
    step();
    check("st_y", ia.y, 8'h15);
    check("st_ych", ia.y_ch, 5);
    check("st_valid", ia.y_valid, 1);
    check("st_fs", ia.frame_start, 0);
    #3 rst_n = 1'b0;
    #1;
    check("arst_y", ia.y, 0);
    check("arst_ych", ia.y_ch, 0);
    check("arst_valid", ia.y_valid, 0);
    #2 rst_n = 1'b1;
    step();
    check("rel_y", ia.y, 8'h15);
    ib.sel = 3'd7;
    step();
    check("oor_y", ib.y, 0);
    check("oor_valid", ib.y_valid, 0);
    ib.sel = 3'd2;
    step();
    check("inr_y", ib.y, 8'h22);
    check("inr_valid", ib.y_valid, 1);
    ia.ch_en = 8'hA5;
    ia.mode = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      c = seq[i/4];
      check($sformatf("scan_ych%0d", i), ia.y_ch, c);
      check($sformatf("scan_y%0d", i), ia.y, 8'h10 + c);
      check($sformatf("scan_fs%0d", i), ia.frame_start, (i % 4 == 0 && c == 0) ? 1 : 0);
    end
    step();
    check("m_ch2", ia.y_ch, 2);
    step();
    ia.ch_en = 8'hA1;
    step();
    check("drop_ych", ia.y_ch, 5);
    check("drop_y", ia.y, 8'h15);
    check("drop_fs", ia.frame_start, 0);
    for (int i = 1; i <= 4; i++) begin
      step();
      check($sformatf("drop_dw%0d", i), ia.y_ch, (i < 4) ? 5 : 7);
    end
    ia.ch_en = 8'h00;
    step();
    check("empty_valid", ia.y_valid, 0);
    check("empty_y", ia.y, 0);
    check("empty_ych", ia.y_ch, 7);
    ia.ch_en = 8'hA5;
    step();
    check("restore_ych", ia.y_ch, 0);
    check("restore_fs", ia.frame_start, 1);
    check("restore_valid", ia.y_valid, 1);
    ia.ch_en = 8'h08;
    step();
    check("one_ych", ia.y_ch, 3);
    check("one_fs", ia.frame_start, 0);
    for (int i = 1; i <= 12; i++) begin
      step();
      check($sformatf("one_ych%0d", i), ia.y_ch, 3);
      check($sformatf("one_fs%0d", i), ia.frame_start, (i % 4 == 0) ? 1 : 0);
    end
    ic.ch_en = 8'hFF;
    ic.mode = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check($sformatf("d1_ych%0d", i), ic.y_ch, i % 8);
      check($sformatf("d1_y%0d", i), ic.y, 8'h30 + (i % 8));
      check($sformatf("d1_fs%0d", i), ic.frame_start, (i % 8 == 0) ? 1 : 0);
    end
    ia.mode = 1'b0;
    ia.sel = 3'd0;
    step();
    ia.ch_en = 8'hA5;
    ia.mode = 1'b1;
    step();
    check("ms_start", ia.y_ch, 0);
    step();
    step();
    step();
    ia.mode = 1'b0;
    ia.sel = 3'd6;
    step();
    check("ms_ych", ia.y_ch, 6);
    check("ms_y", ia.y, 8'h16);
    check("ms_fs", ia.frame_start, 0);
    check("ms_valid", ia.y_valid, 1);
    ia.mode = 1'b1;
    step();
    check("ms_back_ych", ia.y_ch, 0);
    check("ms_back_fs", ia.frame_start, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mux_n_to_1_scan.md
Name: mux_n_to_1_scan

Overview:
- Parametrised, registered N:1 data multiplexer; the sequential successor of the team's fixed 8:1 gate-level mux.
- Two modes:
  - Static: externally selected channel.
  - Scan: time-division auto-scan over an enable mask, with a programmable dwell per channel.
- Sits between parallel sensor/data lanes and a single serial consumer (display, UART framer, logic probe).

Parameters:
- N_CH, 8, number of input channels (2..64; need not be a power of two).
- W, 8, data width per channel in bits.
- DWELL, 4, cycles each enabled channel is held in scan mode (1..65535).
- SEL_W, clog2(N_CH), select/pointer width; derived localparam, not overridable.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous and active-low.
- in_data  input  N_CH*W  packed channels; channel k at bits [k*W +: W].
- mode  input  1  0 = static, 1 = scan.
- sel  input  SEL_W  channel select, used in static mode only.
- ch_en  input  N_CH  scan enable mask; bit k enables channel k.
- y  output  W  selected data, registered.
- y_ch  output  SEL_W  index of the channel currently driving y.
- y_valid  output  1  y/y_ch hold a legal channel.
- frame_start  output  1  one-cycle pulse at the start of each scan frame.

Behaviour:
- Reset (async assert, sync-style release on next clk edge):
  - Outputs: y = 0, y_ch = 0, y_valid = 0, frame_start = 0.
  - Internal: ptr = 0, dwell_cnt = 0, state = IDLE.
  - Reset mid-dwell aborts the frame; there is no resume.
- All outputs are registered. Latency is 1 cycle from in_data/sel to y: y(t+1) = in_data[ptr(t)].
- Static mode (mode = 0):
  - ptr follows sel every cycle.
  - y_valid = 1 if sel < N_CH.
  - Out-of-range sel gives y = 0 and y_valid = 0.
  - ch_en is ignored.
  - frame_start = 0.
- Scan state machine: IDLE -> DWELL -> DWELL ...; stays in IDLE while mode = 0 or ch_en == 0.
  - Entering DWELL (from IDLE, or on a mode 0->1 edge):
    - ptr loads the lowest set bit of ch_en.
    - dwell_cnt = 0.
    - frame_start pulses with the first output of that channel.
  - In DWELL, dwell_cnt increments each cycle. At dwell_cnt == DWELL-1:
    - ptr advances to the next set bit of ch_en above ptr, wrapping to the lowest set bit.
    - dwell_cnt clears.
  - frame_start pulses on the first output cycle after any wrap, i.e. the new ptr is <= the old ptr.
  - A single enabled channel re-selects itself; frame_start pulses every DWELL cycles.
  - ch_en changes mid-dwell:
    - If ch_en[ptr] drops, advance to the next enabled channel on the next edge and clear dwell_cnt. This is not treated as a wrap unless the index decreases.
    - Newly set bits take effect at the next advance.
  - ch_en becomes 0 in scan mode: go to IDLE; y = 0, y_valid = 0, ptr holds.
  - mode 1->0 takes effect on the next edge: static behaviour, scan state cleared.
  - If a mode change and a dwell expiry coincide, the mode change wins.
- DWELL = 1 advances every cycle.
- The dwell counter is sized clog2(DWELL+1) bits and never overflows.

Decomposition:
- Shared package mux_pkg holds:
  - MODE_STATIC = 1'b0, MODE_SCAN = 1'b1.
  - Scan state encodings ST_IDLE, ST_DWELL.
  - A clog2 constant function.
- One sub-module: mux_next_ch_find.
  - Combinational rotate-and-priority-encode.
  - Inputs: ch_en, ptr.
  - Outputs: next index, wrap flag, any flag.
  - Also used to find the lowest set bit (called with ptr = N_CH-1).
- The main block holds the FSM, the dwell counter and the output registers.

Test Plan:
- Reset and static select: N_CH = 8, W = 8, in_data channel k = 8'h10+k, mode = 0, sel = 5.
  - Expect y = 8'h15, y_ch = 5, y_valid = 1 one cycle after sel.
  - Assert rst_n low mid-run: all outputs 0 immediately, without waiting for clk.
- Out-of-range select: N_CH = 6, sel = 7.
  - Expect y = 0, y_valid = 0.
  - Then sel = 2: y = ch2 and y_valid = 1 on the next cycle.
- Full scan: mode = 1, ch_en = 8'b1010_0101, DWELL = 4.
  - Expect y_ch sequence 0,2,5,7,0..., each held 4 cycles.
  - frame_start is high only on the first cycle of each channel 0 period.
- Mask edits mid-dwell: during the channel 2 dwell, clear ch_en[2].
  - Expect a jump to channel 5 on the next edge with a fresh 4-cycle dwell.
  - Then set ch_en = 0: y_valid = 0 next cycle.
  - Restore ch_en: restart at the lowest enabled channel with frame_start.
- Single channel and DWELL = 1: ch_en = 8'b0000_1000.
  - With DWELL = 4: y_ch = 3 constant and frame_start every 4 cycles.
  - With a separate DWELL = 1 build and ch_en = 8'hFF: y_ch increments every cycle and wraps 7 -> 0 with frame_start.
- Mode switching: in scan, set mode = 0 with sel = 6 on the dwell-expiry cycle.
  - Expect y_ch = 6 next cycle; no advance.
  - Back to mode = 1: frame restarts at the lowest enabled channel.
